pc_unit: RTL and testbench

Parametrised program-counter unit for the fetch stage; the next generation of the single-register PC. It selects the next fetch address from reset, exception, exception-return, resolved-branch redirect, return-address-stack pop, hold, or sequential increment, and registers it every clock. It sits between the control/hazard logic and instruction memory, and keeps the exception PC (EPC) and an optional return-address stack (RAS).

---
 rtl/pc_pkg.sv | 25 ++
 rtl/pc_ras.sv | 70 +++++++
 rtl/pc_unit.sv | 135 +++++++++++++
 tb/tb_pc_unit.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared types, default vectors and address helpers for the fetch-stage PC unit.
package pc_pkg;

    localparam int unsigned PC_MAX_XLEN = 64;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h0000_0100;

    typedef enum logic [2:0] {
        SEL_RESET,
        SEL_EXC,
        SEL_ERET,
        SEL_REDIR,
        SEL_RAS,
        SEL_HOLD,
        SEL_SEQ
    } pc_sel_e;

    // Clears the low log2(inc) bits; inc must be a power of two.
    function automatic logic [PC_MAX_XLEN-1:0] align_pc(input logic [PC_MAX_XLEN-1:0] addr,
                                                        input int unsigned inc);
        return addr & ~(PC_MAX_XLEN'(inc) - PC_MAX_XLEN'(1));
    endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// simultaneous push+pop replaces the top in place.
module pc_ras
    import pc_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic [XLEN-1:0] push_addr,
    output logic [XLEN-1:0] top_c,
    output logic            empty,
    output logic            full
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem_q [DEPTH];
    logic [XLEN-1:0] mem_d [DEPTH];
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            empty_q, full_q;

    // ptr_q always indexes the current top entry.
    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        if (push && pop) begin
            mem_d[ptr_q] = push_addr;
        end else if (push) begin
            ptr_d        = ptr_q + PW'(1);
            mem_d[ptr_d] = push_addr;
            if (cnt_q != CW'(DEPTH)) begin
                cnt_d = cnt_q + CW'(1);
            end
        end else if (pop && !empty_q) begin
            ptr_d = ptr_q - PW'(1);
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= '0;
            cnt_q   <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            full_q  <= (cnt_d == CW'(DEPTH));
        end
    end

    // Entry contents are don't-care after reset, so storage has no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign top_c = mem_q[ptr_q];
    assign empty = empty_q;
    assign full  = full_q;

endmodule

// File: rtl/pc_unit.sv
// Fetch-stage program counter with exception PC and optional return-address stack.
// Define PC_RAS_EN to build the RAS; otherwise call/return hints are ignored.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned     XLEN         = 32,
    parameter int unsigned     INC          = 4,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEF_RESET_VECTOR),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(DEF_EXC_VECTOR),
    parameter int unsigned     RAS_DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ctrl_stall,
    input  logic            fetch_ready,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            exc_valid,
    input  logic [XLEN-1:0] exc_pc,
    input  logic            eret,
    input  logic            call_push,
    input  logic [XLEN-1:0] push_addr,
    input  logic            ret_pop,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic [XLEN-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full
);

    logic [XLEN-1:0] pc_q, pc_d;
    logic            pc_valid_q, pc_valid_d;
    logic [XLEN-1:0] epc_q, epc_d;

    logic            adv_c;
    logic            evt_c;
    pc_sel_e         sel_c;
    logic [XLEN-1:0] ras_top_c;
    logic            ras_empty_c;
    logic            ras_full_c;

    assign adv_c = fetch_ready & ~ctrl_stall;
    assign evt_c = exc_valid | eret | redirect_valid;

`ifdef PC_RAS_EN
    logic ras_push_c;
    logic ras_pop_c;

    // Stack only moves on an advancing cycle with no redirecting event.
    assign ras_push_c = call_push & adv_c & ~evt_c & ~rst;
    assign ras_pop_c  = (sel_c == SEL_RAS);

    pc_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push_c),
        .pop       (ras_pop_c),
        .push_addr (push_addr),
        .top_c     (ras_top_c),
        .empty     (ras_empty_c),
        .full      (ras_full_c)
    );
`else
    logic unused_ras_c;

    assign unused_ras_c = ^{call_push, push_addr, ret_pop};
    assign ras_top_c    = '0;
    assign ras_empty_c  = 1'b1;
    assign ras_full_c   = 1'b0;
`endif

    // Next-PC source, highest priority first.
    always_comb begin
        sel_c = SEL_SEQ;
        if (rst) begin
            sel_c = SEL_RESET;
        end else if (exc_valid) begin
            sel_c = SEL_EXC;
        end else if (eret) begin
            sel_c = SEL_ERET;
        end else if (redirect_valid) begin
            sel_c = SEL_REDIR;
`ifdef PC_RAS_EN
        end else if (adv_c && ret_pop && !ras_empty_c) begin
            sel_c = SEL_RAS;
`endif
        end else if (!adv_c) begin
            sel_c = SEL_HOLD;
        end
    end

    always_comb begin
        pc_d       = pc_q;
        pc_valid_d = 1'b1;
        epc_d      = epc_q;
        case (sel_c)
            SEL_RESET: begin
                pc_d       = RESET_VECTOR;
                pc_valid_d = 1'b0;
                epc_d      = '0;
            end
            SEL_EXC: begin
                pc_d  = EXC_VECTOR;
                epc_d = exc_pc;
            end
            SEL_ERET:  pc_d = XLEN'(align_pc(PC_MAX_XLEN'(epc_q), INC));
            SEL_REDIR: pc_d = XLEN'(align_pc(PC_MAX_XLEN'(redirect_pc), INC));
            SEL_RAS:   pc_d = ras_top_c;
            SEL_HOLD:  pc_d = pc_q;
            default:   pc_d = pc_q + XLEN'(INC);
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_VECTOR;
            pc_valid_q <= 1'b0;
            epc_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            epc_q      <= epc_d;
        end
    end

    assign pc        = pc_q;
    assign pc_valid  = pc_valid_q;
    assign epc       = epc_q;
    assign ras_empty = ras_empty_c;
    assign ras_full  = ras_full_c;

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: a queue-based reference model checked every cycle,
// plus literal expectations from the test plan.
module tb_pc_unit;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned INC   = 4;
    localparam int unsigned DEPTH = 4;
`ifdef PC_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            ctrl_stall;
    logic            fetch_ready;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            exc_valid;
    logic [XLEN-1:0] exc_pc;
    logic            eret;
    logic            call_push;
    logic [XLEN-1:0] push_addr;
    logic            ret_pop;
    logic [XLEN-1:0] pc;
    logic            pc_valid;
    logic [XLEN-1:0] epc;
    logic            ras_empty;
    logic            ras_full;

    int n_chk  = 0;
    int n_fail = 0;

    pc_unit #(
        .XLEN         (XLEN),
        .INC          (INC),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h0000_0100),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ctrl_stall     (ctrl_stall),
        .fetch_ready    (fetch_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .exc_pc         (exc_pc),
        .eret           (eret),
        .call_push      (call_push),
        .push_addr      (push_addr),
        .ret_pop        (ret_pop),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .epc            (epc),
        .ras_empty      (ras_empty),
        .ras_full       (ras_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain priority rules, RAS as a bounded queue.
    logic [31:0] m_pc, m_epc;
    logic        m_valid;
    logic [31:0] m_ras[$];
    bit          m_live = 1'b0;

    always @(posedge clk) begin : model
        bit adv;
        adv = fetch_ready && !ctrl_stall;
        if (rst) begin
            m_pc    = 32'h0;
            m_valid = 1'b0;
            m_epc   = 32'h0;
            m_ras.delete();
            m_live  = 1'b1;
        end else if (m_live) begin
            m_valid = 1'b1;
            if (exc_valid) begin
                m_pc  = 32'h100;
                m_epc = exc_pc;
            end else if (eret) begin
                m_pc = m_epc & ~(INC - 1);
            end else if (redirect_valid) begin
                m_pc = redirect_pc & ~(INC - 1);
            end else if (adv) begin
                if (RAS_EN && ret_pop && m_ras.size() > 0) begin
                    m_pc = m_ras.pop_back();
                end else begin
                    m_pc = m_pc + INC;
                end
                if (RAS_EN && call_push) begin
                    m_ras.push_back(push_addr);
                    if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (m_live) begin
            chk("pc", 64'(pc), 64'(m_pc));
            chk("pc_valid", 64'(pc_valid), 64'(m_valid));
            chk("epc", 64'(epc), 64'(m_epc));
            chk("ras_empty", 64'(ras_empty), 64'(m_ras.size() == 0));
            chk("ras_full", 64'(ras_full), 64'(m_ras.size() == DEPTH));
        end
    end

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic idle();
        ctrl_stall     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        exc_valid      = 1'b0;
        exc_pc         = '0;
        eret           = 1'b0;
        call_push      = 1'b0;
        push_addr      = '0;
        ret_pop        = 1'b0;
    endtask

    task automatic push(input logic [31:0] a);
        call_push = 1'b1;
        push_addr = a;
        tick();
        call_push = 1'b0;
    endtask

    task automatic pop();
        ret_pop = 1'b1;
        tick();
        ret_pop = 1'b0;
    endtask

    initial begin
        idle();
        rst         = 1'b1;
        fetch_ready = 1'b0;
        tick(2);
        chk("rst_pc", 64'(pc), 64'h0);
        chk("rst_valid", 64'(pc_valid), 64'h0);
        chk("rst_epc", 64'(epc), 64'h0);
        chk("rst_empty", 64'(ras_empty), 64'h1);
        chk("rst_full", 64'(ras_full), 64'h0);

        // Sequential fetch after reset.
        rst         = 1'b0;
        fetch_ready = 1'b1;
        tick();
        chk("seq_4", 64'(pc), 64'h4);
        chk("seq_valid", 64'(pc_valid), 64'h1);
        tick(2);
        chk("seq_12", 64'(pc), 64'hC);
        tick();
        chk("seq_16", 64'(pc), 64'h10);

        // Stall holds; redirect overrides stall and is aligned.
        ctrl_stall = 1'b1;
        tick(2);
        chk("stall_hold", 64'(pc), 64'h10);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        tick();
        chk("redir_align", 64'(pc), 64'h200);
        idle();

        // Fetch not ready also holds.
        fetch_ready = 1'b0;
        tick();
        chk("nready_hold", 64'(pc), 64'h200);
        fetch_ready = 1'b1;

        // Exception beats redirect; eret returns to epc.
        exc_valid      = 1'b1;
        exc_pc         = 32'h44;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick();
        chk("exc_pc", 64'(pc), 64'h100);
        chk("exc_epc", 64'(epc), 64'h44);
        idle();
        eret = 1'b1;
        tick();
        chk("eret_pc", 64'(pc), 64'h44);
        idle();

        // Basic push/pop.
        push(32'hA0);
        push(32'hB0);
        pop();
        if (RAS_EN) chk("pop_b0", 64'(pc), 64'hB0);
        pop();
        if (RAS_EN) chk("pop_a0", 64'(pc), 64'hA0);
        pop();
        if (RAS_EN) chk("pop_empty_seq", 64'(pc), 64'hA4);
        chk("pop_empty_flag", 64'(ras_empty), 64'h1);

        // Overfill: oldest entry is overwritten.
        for (int k = 1; k <= 5; k++) push(32'(k) * 32'h1000);
        if (RAS_EN) chk("full_flag", 64'(ras_full), 64'h1);
        for (int k = 5; k >= 2; k--) begin
            pop();
            if (RAS_EN) chk("pop_wrap", 64'(pc), 64'(32'(k) * 32'h1000));
        end
        pop();
        if (RAS_EN) chk("pop_wrap_seq", 64'(pc), 64'h2004);

        // Push+pop together replaces the top.
        push(32'h600);
        call_push = 1'b1;
        push_addr = 32'h700;
        ret_pop   = 1'b1;
        tick();
        idle();
        if (RAS_EN) chk("pushpop_old_top", 64'(pc), 64'h600);
        pop();
        if (RAS_EN) chk("pushpop_new_top", 64'(pc), 64'h700);

        // RAS ignored during stall and during a redirect.
        ctrl_stall = 1'b1;
        push(32'h900);
        ctrl_stall     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        push(32'h904);
        idle();
        chk("ignored_push_empty", 64'(ras_empty), 64'h1);
        chk("wrap_start", 64'(pc), 64'hFFFF_FFFC);
        tick();
        chk("wrap_zero", 64'(pc), 64'h0);

        // Reset during pop and exception.
        push(32'h80);
        exc_valid = 1'b1;
        exc_pc    = 32'h55;
        ret_pop   = 1'b1;
        rst       = 1'b1;
        tick();
        idle();
        chk("rst2_pc", 64'(pc), 64'h0);
        chk("rst2_valid", 64'(pc_valid), 64'h0);
        chk("rst2_epc", 64'(epc), 64'h0);
        chk("rst2_empty", 64'(ras_empty), 64'h1);
        rst = 1'b0;
        tick(2);
        chk("rst2_resume", 64'(pc), 64'h8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
